// File: rtl/game_display_pkg.sv
// Shared types and constants for the scoreboard display scheduler.
// Holds the FSM state type, well-known message codes and the BCD split helper.
package game_display_pkg;

    typedef enum logic {
        SCORE    = 1'b0,
        SHOW_MSG = 1'b1
    } state_t;

    localparam logic [7:0] MSG_WIN  = 8'hAA;
    localparam logic [7:0] MSG_LOSE = 8'hEE;

    // Binary 0..15 to two decimal digits {upper, lower}.
    function automatic logic [7:0] bcd_split(input logic [3:0] bin);
        logic [7:0] r;
        if (bin >= 4'd10) r = {4'd1, bin - 4'd10};
        else              r = {4'd0, bin};
        return r;
    endfunction

endpackage

// File: rtl/game_display_scheduler_if.sv
// Message request handshake between the game FSM (master) and the scheduler (slave).
// Ports: i_Msg_Valid/i_Msg_Code/i_Msg_Blink request, o_Msg_Ready accept, o_Msg_Done completion.
interface game_display_scheduler_if;

    logic       i_Msg_Valid;
    logic [7:0] i_Msg_Code;
    logic       i_Msg_Blink;
    logic       o_Msg_Ready;
    logic       o_Msg_Done;

    modport master (
        output i_Msg_Valid,
        output i_Msg_Code,
        output i_Msg_Blink,
        input  o_Msg_Ready,
        input  o_Msg_Done
    );

    modport slave (
        input  i_Msg_Valid,
        input  i_Msg_Code,
        input  i_Msg_Blink,
        output o_Msg_Ready,
        output o_Msg_Done
    );

endinterface

// File: rtl/display_blink_timer.sv
// Free-running half-period counter with a phase toggle and synchronous restart.
// Ports: i_Clk, i_Rst, i_Restart (phase 0, count 0), i_Enable (advance), o_Phase.
module display_blink_timer
    import game_display_pkg::*;
#(
    parameter int BLINK_CLKS = 6250000
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Restart,
    input  logic i_Enable,
    output logic o_Phase
);

    localparam int CW = (BLINK_CLKS > 1) ? $clog2(BLINK_CLKS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_CLKS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (i_Restart) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (i_Enable) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign o_Phase = phase_q;

endmodule

// File: rtl/game_display_scheduler.sv
// Shares the 2-digit scoreboard between the persistent score and timed messages.
// Ports: i_Clk, i_Rst, i_Score, i_Clear, msg_if (request handshake), o_Digit_Upper/Lower, o_Blank.
module game_display_scheduler
    import game_display_pkg::*;
#(
    parameter int MSG_HOLD_CLKS = 50000000,
    parameter int BLINK_CLKS    = 6250000
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst,
    input  logic [3:0]                i_Score,
    input  logic                      i_Clear,
    game_display_scheduler_if.slave   msg_if,
    output logic [3:0]                o_Digit_Upper,
    output logic [3:0]                o_Digit_Lower,
    output logic                      o_Blank
);

    localparam int HW = $clog2(MSG_HOLD_CLKS);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MSG_HOLD_CLKS - 1);

    state_t        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          blink_q, blink_d;
    logic [3:0]    upper_q, upper_d;
    logic [3:0]    lower_q, lower_d;
    logic          done_q, done_d;
    logic          restart;
    logic          phase;
    logic [7:0]    score_bcd;

    assign score_bcd = bcd_split(i_Score);

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        blink_d = blink_q;
        upper_d = upper_q;
        lower_d = lower_q;
        done_d  = 1'b0;
        restart = 1'b0;
        unique case (state_q)
            SCORE: begin
                upper_d = score_bcd[7:4];
                lower_d = score_bcd[3:0];
                if (msg_if.i_Msg_Valid && !i_Clear) begin
                    state_d = SHOW_MSG;
                    upper_d = msg_if.i_Msg_Code[7:4];
                    lower_d = msg_if.i_Msg_Code[3:0];
                    blink_d = msg_if.i_Msg_Blink;
                    hold_d  = '0;
                    restart = 1'b1;
                end
            end
            SHOW_MSG: begin
                if (i_Clear) begin
                    // Abort: straight back to score, no completion pulse.
                    state_d = SCORE;
                    hold_d  = '0;
                    upper_d = score_bcd[7:4];
                    lower_d = score_bcd[3:0];
                end else if (hold_q == HOLD_LAST) begin
                    state_d = SCORE;
                    hold_d  = '0;
                    done_d  = 1'b1;
                    upper_d = score_bcd[7:4];
                    lower_d = score_bcd[3:0];
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = SCORE;
            end
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q <= SCORE;
            hold_q  <= '0;
            blink_q <= 1'b0;
            upper_q <= 4'd0;
            lower_q <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            blink_q <= blink_d;
            upper_q <= upper_d;
            lower_q <= lower_d;
            done_q  <= done_d;
        end
    end

    // Timer only runs while a message is up; restarted on accept so the
    // first BLINK_CLKS cycles of every message are visible.
    display_blink_timer #(
        .BLINK_CLKS (BLINK_CLKS)
    ) u_blink (
        .i_Clk     (i_Clk),
        .i_Rst     (i_Rst),
        .i_Restart (restart),
        .i_Enable  (state_q == SHOW_MSG),
        .o_Phase   (phase)
    );

    assign msg_if.o_Msg_Ready = (state_q == SCORE);
    assign msg_if.o_Msg_Done  = done_q;
    assign o_Digit_Upper      = upper_q;
    assign o_Digit_Lower      = lower_q;
    assign o_Blank            = (state_q == SHOW_MSG) && blink_q && phase;

endmodule

// File: tb/tb_game_display_scheduler.sv
// Bench for game_display_scheduler: directed scenarios then random traffic,
// checked against a cycle-age reference model of the scoreboard.
module tb_game_display_scheduler;

    localparam int H = 10;
    localparam int B = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] score;
    logic       clear;
    logic [3:0] d_up;
    logic [3:0] d_lo;
    logic       blank;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: is a message up, how many cycles it has been shown
    bit         m_msg;
    int         m_age;
    logic [7:0] m_code;
    bit         m_blink;
    logic [3:0] m_up;
    logic [3:0] m_lo;
    bit         m_done;

    game_display_scheduler_if bus ();

    game_display_scheduler #(
        .MSG_HOLD_CLKS (H),
        .BLINK_CLKS    (B)
    ) dut (
        .i_Clk         (clk),
        .i_Rst         (rst),
        .i_Score       (score),
        .i_Clear       (clear),
        .msg_if        (bus),
        .o_Digit_Upper (d_up),
        .o_Digit_Lower (d_lo),
        .o_Blank       (blank)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic show_score(input logic [3:0] s);
        int v;
        v    = int'(s);
        m_up = 4'(v / 10);
        m_lo = 4'(v % 10);
    endtask

    // Advance the model with the current inputs, clock once, compare.
    task automatic step();
        bit         acc;
        logic [3:0] e_up;
        logic [3:0] e_lo;
        bit         e_bl;
        acc = 0;
        if (rst) begin
            m_msg  = 0;
            m_up   = 4'd0;
            m_lo   = 4'd0;
            m_done = 0;
        end else if (m_msg) begin
            m_done = 0;
            if (clear) begin
                m_msg = 0;
                show_score(score);
            end else if (m_age == H) begin
                m_msg  = 0;
                m_done = 1;
                show_score(score);
            end else begin
                m_age++;
            end
        end else begin
            m_done = 0;
            if (bus.i_Msg_Valid && !clear) begin
                acc     = 1;
                m_msg   = 1;
                m_age   = 1;
                m_code  = bus.i_Msg_Code;
                m_blink = bus.i_Msg_Blink;
            end else begin
                show_score(score);
            end
        end
        @(posedge clk);
        #1;
        if (acc) bus.i_Msg_Valid = 1'b0;
        e_up = m_msg ? m_code[7:4] : m_up;
        e_lo = m_msg ? m_code[3:0] : m_lo;
        e_bl = m_msg && m_blink && ((((m_age - 1) / B) % 2) == 1);
        chk("upper", 8'(d_up), 8'(e_up));
        chk("lower", 8'(d_lo), 8'(e_lo));
        chk("blank", 8'(blank), 8'(e_bl));
        chk("ready", 8'(bus.o_Msg_Ready), 8'(!m_msg));
        chk("done",  8'(bus.o_Msg_Done), 8'(m_done));
    endtask

    task automatic request(input logic [7:0] code, input bit blk);
        bus.i_Msg_Valid = 1'b1;
        bus.i_Msg_Code  = code;
        bus.i_Msg_Blink = blk;
    endtask

    initial begin
        rst             = 1'b1;
        score           = 4'd0;
        clear           = 1'b0;
        bus.i_Msg_Valid = 1'b0;
        bus.i_Msg_Code  = 8'h00;
        bus.i_Msg_Blink = 1'b0;
        m_msg = 0; m_age = 0; m_code = 8'h00; m_blink = 0;
        m_up = 4'd0; m_lo = 4'd0; m_done = 0;

        // 1. reset
        step();
        step();
        chk("rst_ready", 8'(bus.o_Msg_Ready), 8'd1);
        chk("rst_up", 8'(d_up), 8'd0);
        rst = 1'b0;

        // 2. score split
        score = 4'd13; step();
        chk("s13", {d_up, d_lo}, 8'h13);
        score = 4'd9;  step();
        chk("s9", {d_up, d_lo}, 8'h09);
        score = 4'd15; step();
        chk("s15", {d_up, d_lo}, 8'h15);

        // 3. steady lose message
        request(8'hEE, 1'b0);
        for (int i = 0; i < 13; i++) step();

        // 4. blinking win message
        request(8'hAA, 1'b1);
        for (int i = 0; i < 13; i++) step();

        // 5. second request stalled behind the first
        score = 4'd7;
        request(8'h42, 1'b1);
        step();
        step();
        request(8'h35, 1'b0);
        for (int i = 0; i < 24; i++) step();

        // 6a. clear mid-message
        request(8'hEE, 1'b1);
        for (int i = 0; i < 4; i++) step();
        clear = 1'b1; step();
        clear = 1'b0;
        for (int i = 0; i < 12; i++) step();

        // 6b. clear in SCORE blocks acceptance
        request(8'h21, 1'b0);
        clear = 1'b1; step();
        clear = 1'b0;
        for (int i = 0; i < 12; i++) step();

        // 6c. reset mid-message
        request(8'hAA, 1'b1);
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1; step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) step();

        // random traffic
        for (int i = 0; i < 600; i++) begin
            score = 4'($urandom_range(0, 15));
            clear = ($urandom_range(0, 29) == 0);
            rst   = ($urandom_range(0, 99) == 0);
            if (!bus.i_Msg_Valid && $urandom_range(0, 3) == 0)
                request(8'($urandom), 1'($urandom));
            step();
        end
        rst   = 1'b0;
        clear = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
